lsu_mem_controller: RTL and testbench
=====================================

// Module: lsu_mem_controller
// PURPOSE
//  Responder side of the LSU data-memory handshake: accepts read/write requests from NUM_CONSUMERS LSUs,
//  arbitrates them onto NUM_CHANNELS external memory channels, relays memory responses back.
//  Sits between the per-thread LSUs of all cores and the data memory.
// PARAMETERS
//  ADDR_BITS      8  address width
//  DATA_BITS      8  data width
//  NUM_CONSUMERS  8  LSU request ports
//  NUM_CHANNELS   2  concurrent memory channels (1..NUM_CONSUMERS)
//  WRITE_ENABLE   1  0 = read-only instance; write logic removed, consumer_write_ready tied 0
// PORTS
//  clk                    in   1                      clock
//  reset                  in   1                      synchronous, active-high
//  consumer_read_valid    in   [NC]                   LSU read request, held until ready seen
//  consumer_read_address  in   [NC][ADDR_BITS]        read address
//  consumer_read_ready    out  [NC]                   read done; data valid while high
//  consumer_read_data     out  [NC][DATA_BITS]        read data
//  consumer_write_valid   in   [NC]                   LSU write request
//  consumer_write_address in   [NC][ADDR_BITS]        write address
//  consumer_write_data    in   [NC][DATA_BITS]        write data
//  consumer_write_ready   out  [NC]                   write done
//  mem_read_valid         out  [NCH]                  channel read request
//  mem_read_address       out  [NCH][ADDR_BITS]       channel read address
//  mem_read_ready         in   [NCH]                  memory read complete
//  mem_read_data          in   [NCH][DATA_BITS]       memory read data
//  mem_write_valid        out  [NCH]                  channel write request
//  mem_write_address      out  [NCH][ADDR_BITS]       channel write address
//  mem_write_data         out  [NCH][DATA_BITS]       channel write data
//  mem_write_ready        in   [NCH]                  memory write complete
// BEHAVIOUR
//  Reset: all outputs 0; every channel IDLE; claim mask 0; current_consumer 0. Reset mid-transaction
//   abandons it (mem_*_valid drop next edge); consumer must re-request.
//  Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
//  IDLE: scan consumers 0..NC-1; first with (read_valid|write_valid) and not claimed wins;
//   read beats write for same consumer. Channels scan in index order within one cycle; a consumer
//   picked by a lower channel is excluded for higher channels the same cycle (no double grant).
//   On grant: set claim bit, record consumer, register address/data, assert mem_*_valid next edge.
//  *_WAITING: hold mem_*_valid/address/data stable. On mem_*_ready: drop mem_*_valid, assert
//   consumer_*_ready (read: latch mem_read_data into consumer_read_data), go *_RELAYING.
//  *_RELAYING: hold consumer_*_ready and data until consumer's valid sampled low; then drop ready,
//   clear claim bit, IDLE. Consumer still high -> stay (four-phase handshake).
//  Latency: consumer valid at edge N -> mem valid high after N+1; mem ready at edge K -> consumer ready
//   high after K+1; consumer valid low at edge R -> ready low and channel IDLE after R+1. Min 4 cycles.
//  A channel may grant again in the cycle after returning to IDLE (no bubble beyond that).
//  Fixed priority: lowest consumer index wins; starvation acceptable (LSUs of a block are lockstep).
//  Consumer valid dropped while WAITING: illegal; transaction completes, ready pulses one cycle.
//  mem ready while channel IDLE or RELAYING: ignored.
//  consumer_read_data holds last value when ready low (not cleared).
// STRUCTURE
//  Package mem_ctrl_pkg: channel_state_t enum (5 states, 3 bits), shared with LSU state constants.
//  Sub-module mem_channel_fsm: one channel's FSM + registers, instantiated NUM_CHANNELS times;
//   top level holds claim mask, grant scan and output muxing to consumers.
// TESTING
//  1 read: C0 read addr 0x10, mem ready 2 cyc later data 0xA5 -> C0 ready, data 0xA5; drop valid -> idle.
//  2 write: C3 write 0x20<=0x5A -> mem_write addr 0x20 data 0x5A; after mem ready, C3 write_ready high.
//  3 contention: C1,C2,C5 read same cycle, 2 channels -> ch0=C1, ch1=C2; C5 served after first release.
//  4 hold: C0 keeps valid 3 cycles after ready -> ready stays high, no regrant of C0, claim held.
//  5 reset mid-WAITING -> all valid/ready 0 next edge, states IDLE, subsequent request served normally.
//  6 stall: mem ready withheld 20 cycles -> mem_read_valid/address stable throughout, no consumer ready.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LSU data-memory controller: channel FSM states,
// LSU-side state encoding and index-width helper.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ChIdle          = 3'd0,
    ChReadWaiting   = 3'd1,
    ChWriteWaiting  = 3'd2,
    ChReadRelaying  = 3'd3,
    ChWriteRelaying = 3'd4
  } channel_state_t;

  // Request-side states used by the per-thread LSUs talking to this controller.
  localparam logic [1:0] LsuIdle       = 2'd0;
  localparam logic [1:0] LsuRequesting = 2'd1;
  localparam logic [1:0] LsuWaiting    = 2'd2;
  localparam logic [1:0] LsuDone       = 2'd3;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One external memory channel: holds a granted request until memory answers,
// then relays completion to the owning consumer with a four-phase handshake.
module mem_channel_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned IDX_BITS      = idx_bits(NUM_CONSUMERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grant_valid,
  input  logic                     grant_read,
  input  logic [IDX_BITS-1:0]      grant_consumer,
  input  logic [ADDR_BITS-1:0]     grant_address,
  input  logic [DATA_BITS-1:0]     grant_data,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic                     mem_read_ready,
  input  logic                     mem_write_ready,
  output logic                     idle,
  output logic [IDX_BITS-1:0]      consumer,
  output logic                     read_relaying,
  output logic                     write_relaying,
  output logic                     read_done,
  output logic                     release_claim,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data
);

  channel_state_t         state_q, state_d;
  logic [IDX_BITS-1:0]    consumer_q, consumer_d;
  logic [ADDR_BITS-1:0]   address_q, address_d;
  logic [DATA_BITS-1:0]   data_q, data_d;

  always_comb begin
    state_d       = state_q;
    consumer_d    = consumer_q;
    address_d     = address_q;
    data_d        = data_q;
    read_done     = 1'b0;
    release_claim = 1'b0;
    case (state_q)
      ChIdle: begin
        if (grant_valid) begin
          consumer_d = grant_consumer;
          address_d  = grant_address;
          data_d     = grant_data;
          state_d    = grant_read ? ChReadWaiting : ChWriteWaiting;
        end
      end
      ChReadWaiting: begin
        if (mem_read_ready) begin
          state_d   = ChReadRelaying;
          read_done = 1'b1;
        end
      end
      ChWriteWaiting: begin
        if (mem_write_ready) state_d = ChWriteRelaying;
      end
      // Stay until the consumer withdraws its request.
      ChReadRelaying: begin
        if (!consumer_read_valid[consumer_q]) begin
          state_d       = ChIdle;
          release_claim = 1'b1;
        end
      end
      ChWriteRelaying: begin
        if (!consumer_write_valid[consumer_q]) begin
          state_d       = ChIdle;
          release_claim = 1'b1;
        end
      end
      default: state_d = ChIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ChIdle;
      consumer_q <= '0;
      address_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      consumer_q <= consumer_d;
      address_q  <= address_d;
      data_q     <= data_d;
    end
  end

  assign idle              = (state_q == ChIdle);
  assign consumer          = consumer_q;
  assign read_relaying     = (state_q == ChReadRelaying);
  assign write_relaying    = (state_q == ChWriteRelaying);
  assign mem_read_valid    = (state_q == ChReadWaiting);
  assign mem_read_address  = address_q;
  assign mem_write_valid   = (state_q == ChWriteWaiting);
  assign mem_write_address = address_q;
  assign mem_write_data    = data_q;

endmodule

// File: rtl/lsu_mem_controller.sv
// LSU data-memory responder: fixed-priority grant of consumer requests onto
// memory channels, claim tracking and routing of completions back to consumers.
module lsu_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CONSUMERS-1:0]                   consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]    consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                   consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]    consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                   consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]    consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]    consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                   consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                    mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]     mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                    mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]     mem_read_data,
  output logic [NUM_CHANNELS-1:0]                    mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]     mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]     mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                    mem_write_ready
);

  localparam int unsigned IdxBits = idx_bits(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d, taken, write_request;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;

  logic [NUM_CHANNELS-1:0]                 ch_idle, grant_valid, grant_read;
  logic [NUM_CHANNELS-1:0]                 ch_read_relaying, ch_write_relaying;
  logic [NUM_CHANNELS-1:0]                 ch_read_done, ch_release, ch_mem_write_valid;
  logic [NUM_CHANNELS-1:0][IdxBits-1:0]    grant_consumer, ch_consumer;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  grant_address, ch_mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  grant_data, ch_mem_write_data;

  // Read-only instances never see a write request, so no write is ever granted.
  assign write_request = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  // Channels scan in index order; a consumer picked by a lower channel is hidden
  // from higher channels in the same cycle.
  always_comb begin
    taken          = claim_q;
    grant_valid    = '0;
    grant_read     = '0;
    grant_consumer = '0;
    grant_address  = '0;
    grant_data     = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        if (ch_idle[ch] && !grant_valid[ch] && !taken[c] &&
            (consumer_read_valid[c] || write_request[c])) begin
          grant_valid[ch]    = 1'b1;
          grant_read[ch]     = consumer_read_valid[c];
          grant_consumer[ch] = IdxBits'(c);
          grant_address[ch]  = consumer_read_valid[c] ? consumer_read_address[c]
                                                      : consumer_write_address[c];
          grant_data[ch]     = consumer_write_data[c];
          taken[c]           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    claim_d = claim_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_release[ch]) claim_d[ch_consumer[ch]] = 1'b0;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (grant_valid[ch]) claim_d[grant_consumer[ch]] = 1'b1;
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_read_done[ch]) read_data_d[ch_consumer[ch]] = mem_read_data[ch];
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_read_relaying[ch]) consumer_read_ready[ch_consumer[ch]] = 1'b1;
      if ((WRITE_ENABLE != 0) && ch_write_relaying[ch]) begin
        consumer_write_ready[ch_consumer[ch]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      claim_q     <= '0;
      read_data_q <= '0;
    end else begin
      claim_q     <= claim_d;
      read_data_q <= read_data_d;
    end
  end

  assign consumer_read_data = read_data_q;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
    mem_channel_fsm #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .IDX_BITS     (IdxBits)
    ) u_fsm (
      .clk                 (clk),
      .reset               (reset),
      .grant_valid         (grant_valid[ch]),
      .grant_read          (grant_read[ch]),
      .grant_consumer      (grant_consumer[ch]),
      .grant_address       (grant_address[ch]),
      .grant_data          (grant_data[ch]),
      .consumer_read_valid (consumer_read_valid),
      .consumer_write_valid(consumer_write_valid),
      .mem_read_ready      (mem_read_ready[ch]),
      .mem_write_ready     (mem_write_ready[ch]),
      .idle                (ch_idle[ch]),
      .consumer            (ch_consumer[ch]),
      .read_relaying       (ch_read_relaying[ch]),
      .write_relaying      (ch_write_relaying[ch]),
      .read_done           (ch_read_done[ch]),
      .release_claim       (ch_release[ch]),
      .mem_read_valid      (mem_read_valid[ch]),
      .mem_read_address    (mem_read_address[ch]),
      .mem_write_valid     (ch_mem_write_valid[ch]),
      .mem_write_address   (ch_mem_write_address[ch]),
      .mem_write_data      (ch_mem_write_data[ch])
    );

    if (WRITE_ENABLE != 0) begin : g_write
      assign mem_write_valid[ch]   = ch_mem_write_valid[ch];
      assign mem_write_address[ch] = ch_mem_write_address[ch];
      assign mem_write_data[ch]    = ch_mem_write_data[ch];
    end else begin : g_no_write
      assign mem_write_valid[ch]   = 1'b0;
      assign mem_write_address[ch] = '0;
      assign mem_write_data[ch]    = '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Bench for lsu_mem_controller: directed scenarios with literal expectations plus
// randomized LSU/memory traffic, all checked every cycle against a transaction model.
module tb_lsu_mem_controller;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 8;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]           crv, crr, cwv, cwr;
  logic [NC-1:0][AB-1:0]   cra, cwa;
  logic [NC-1:0][DB-1:0]   crd, cwd;
  logic [NCH-1:0]          mrv, mrr, mwv, mwr;
  logic [NCH-1:0][AB-1:0]  mra, mwa;
  logic [NCH-1:0][DB-1:0]  mrd, mwd;

  lsu_mem_controller #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Transaction-level model: each channel either free or owning one request that
  // is awaiting memory (resp=0) or awaiting the consumer's withdrawal (resp=1).
  bit            m_busy[NCH];
  bit            m_read[NCH];
  bit            m_resp[NCH];
  int            m_cons[NCH];
  logic [AB-1:0] m_addr[NCH];
  logic [DB-1:0] m_wdata[NCH];
  logic [DB-1:0] m_rdata[NC];

  always @(posedge clk) begin : p_model
    bit claimed[NC];
    bit was_busy[NCH];
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_busy[ch] = 0; m_resp[ch] = 0;
      end
      for (int c = 0; c < NC; c++) m_rdata[c] = '0;
    end else begin
      for (int c = 0; c < NC; c++) claimed[c] = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        was_busy[ch] = m_busy[ch];
        if (m_busy[ch]) claimed[m_cons[ch]] = 1;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (!was_busy[ch]) begin
          for (int c = 0; c < NC; c++) begin
            if (!m_busy[ch] && !claimed[c] && (crv[c] || cwv[c])) begin
              m_busy[ch]  = 1;
              m_resp[ch]  = 0;
              m_read[ch]  = crv[c];
              m_cons[ch]  = c;
              m_addr[ch]  = crv[c] ? cra[c] : cwa[c];
              m_wdata[ch] = cwd[c];
              claimed[c]  = 1;
            end
          end
        end else if (!m_resp[ch]) begin
          if (m_read[ch] ? mrr[ch] : mwr[ch]) begin
            m_resp[ch] = 1;
            if (m_read[ch]) m_rdata[m_cons[ch]] = mrd[ch];
          end
        end else if (!(m_read[ch] ? crv[m_cons[ch]] : cwv[m_cons[ch]])) begin
          m_busy[ch] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : p_compare
    bit er, ew;
    if (chk_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        er = m_busy[ch] && m_read[ch] && !m_resp[ch];
        ew = m_busy[ch] && !m_read[ch] && !m_resp[ch];
        check("mem_read_valid", ch, mrv[ch], er);
        check("mem_write_valid", ch, mwv[ch], ew);
        if (er) check("mem_read_address", ch, mra[ch], m_addr[ch]);
        if (ew) begin
          check("mem_write_address", ch, mwa[ch], m_addr[ch]);
          check("mem_write_data", ch, mwd[ch], m_wdata[ch]);
        end
      end
      for (int c = 0; c < NC; c++) begin
        er = 0; ew = 0;
        for (int ch = 0; ch < NCH; ch++) begin
          if (m_busy[ch] && m_resp[ch] && m_cons[ch] == c) begin
            if (m_read[ch]) er = 1; else ew = 1;
          end
        end
        check("consumer_read_ready", c, crr[c], er);
        check("consumer_write_ready", c, cwr[c], ew);
        check("consumer_read_data", c, crd[c], m_rdata[c]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    crv = '0; cra = '0; cwv = '0; cwa = '0; cwd = '0;
    mrr = '0; mrd = '0; mwr = '0;
  endtask

  int   a_st[NC];
  bit   a_rd[NC];
  int   a_hold[NC];
  int   a_wait[NC];
  bit   timed_out;

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_mem_read_valid", 0, mrv, 0);
    check("reset_mem_write_valid", 0, mwv, 0);
    check("reset_read_ready", 0, crr, 0);
    check("reset_read_data", 0, crd[0], 0);
    reset = 1'b0;
    tick();

    // Single read
    crv[0] = 1; cra[0] = 8'h10;
    tick();
    check("t1_mem_read_valid", 0, mrv[0], 1);
    check("t1_mem_read_address", 0, mra[0], 8'h10);
    tick();
    mrr[0] = 1; mrd[0] = 8'hA5;
    tick();
    mrr[0] = 0; mrd[0] = 8'h00;
    check("t1_read_ready", 0, crr[0], 1);
    check("t1_read_data", 0, crd[0], 8'hA5);
    check("t1_mem_valid_dropped", 0, mrv[0], 0);
    crv[0] = 0;
    tick();
    check("t1_ready_low", 0, crr[0], 0);
    check("t1_data_held", 0, crd[0], 8'hA5);

    // Single write
    cwv[3] = 1; cwa[3] = 8'h20; cwd[3] = 8'h5A;
    tick();
    check("t2_mem_write_valid", 0, mwv[0], 1);
    check("t2_mem_write_address", 0, mwa[0], 8'h20);
    check("t2_mem_write_data", 0, mwd[0], 8'h5A);
    tick();
    mwr[0] = 1;
    tick();
    mwr[0] = 0;
    check("t2_write_ready", 3, cwr[3], 1);
    cwv[3] = 0;
    tick();
    check("t2_write_ready_low", 3, cwr[3], 0);

    // Contention on two channels
    crv[1] = 1; cra[1] = 8'h31;
    crv[2] = 1; cra[2] = 8'h32;
    crv[5] = 1; cra[5] = 8'h35;
    tick();
    check("t3_ch0_address", 0, mra[0], 8'h31);
    check("t3_ch1_address", 1, mra[1], 8'h32);
    check("t3_both_valid", 0, mrv, 2'b11);
    mrr = 2'b11; mrd[0] = 8'h11; mrd[1] = 8'h22;
    tick();
    mrr = '0;
    check("t3_ready_c1", 1, crr[1], 1);
    check("t3_ready_c2", 2, crr[2], 1);
    check("t3_c5_waiting", 5, crr[5], 0);
    crv[1] = 0;
    tick();
    tick();
    check("t3_c5_granted", 0, mrv[0], 1);
    check("t3_c5_address", 0, mra[0], 8'h35);
    crv[2] = 0;
    mrr[0] = 1; mrd[0] = 8'h3C;
    tick();
    mrr[0] = 0;
    check("t3_c5_data", 5, crd[5], 8'h3C);
    crv[5] = 0;
    tick();

    // Consumer holds valid after ready
    crv[0] = 1; cra[0] = 8'h44;
    tick();
    mrr[0] = 1; mrd[0] = 8'h77;
    tick();
    mrr[0] = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_ready_held", 0, crr[0], 1);
      check("t4_no_regrant", 0, mrv, 0);
    end
    crv[0] = 0;
    tick();
    check("t4_ready_low", 0, crr[0], 0);

    // Reset while waiting on memory
    crv[4] = 1; cra[4] = 8'h50;
    tick();
    check("t5_waiting", 0, mrv[0], 1);
    reset = 1;
    tick();
    check("t5_abandoned", 0, mrv, 0);
    check("t5_data_cleared", 0, crd[0], 0);
    reset = 0;
    tick();
    check("t5_regrant", 0, mrv[0], 1);
    check("t5_regrant_address", 0, mra[0], 8'h50);
    mrr[0] = 1; mrd[0] = 8'h99;
    tick();
    mrr[0] = 0;
    check("t5_data", 4, crd[4], 8'h99);
    crv[4] = 0;
    tick();

    // Memory stall
    crv[6] = 1; cra[6] = 8'h66;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_stall_valid", 0, mrv[0], 1);
      check("t6_stall_address", 0, mra[0], 8'h66);
      check("t6_no_ready", 6, crr[6], 0);
    end
    mrr[0] = 1; mrd[0] = 8'hC6;
    tick();
    mrr[0] = 0;
    check("t6_data", 6, crd[6], 8'hC6);
    crv[6] = 0;
    tick();

    // Random traffic
    for (int c = 0; c < NC; c++) begin
      a_st[c] = 0; a_wait[c] = 0;
    end
    timed_out = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        case (a_st[c])
          0: if ($urandom_range(0, 5) == 0) begin
            a_rd[c] = ($urandom_range(0, 1) == 0);
            if (a_rd[c]) begin
              crv[c] = 1; cra[c] = AB'($urandom);
            end else begin
              cwv[c] = 1; cwa[c] = AB'($urandom); cwd[c] = DB'($urandom);
            end
            a_wait[c] = 0;
            a_st[c] = 1;
          end
          1: begin
            a_wait[c]++;
            if (a_rd[c] ? crr[c] : cwr[c]) begin
              a_hold[c] = $urandom_range(0, 2);
              a_st[c] = 2;
            end else if ($urandom_range(0, 99) == 0) begin
              crv[c] = 0; cwv[c] = 0; a_st[c] = 0;
            end else if (a_wait[c] > 3000 && !timed_out) begin
              timed_out = 1;
              check("lsu_request_timeout", c, a_wait[c], 0);
            end
          end
          default: begin
            if (a_hold[c] == 0) begin
              crv[c] = 0; cwv[c] = 0; a_st[c] = 0;
            end else begin
              a_hold[c]--;
            end
          end
        endcase
      end
      for (int ch = 0; ch < NCH; ch++) begin
        mrr[ch] = ($urandom_range(0, 3) == 0);
        mwr[ch] = ($urandom_range(0, 3) == 0);
        mrd[ch] = DB'($urandom);
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
